// File: rtl/pc_stack_seq_if.sv
// Fetch-control bundle between the front end and the PC sequencer.
// The sequencer takes the slave modport; whoever steers fetch takes master.
interface pc_stack_seq_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4,
  parameter int OW    = 4
) ();
  localparam int SPW = $clog2(DEPTH) + 1;

  logic           i_EN;
  logic           i_SEL_JMP;
  logic [AW-1:0]  i_JMP_ADDR;
  logic           i_SEL_BR;
  logic [OW-1:0]  i_BR_OFF;
  logic           i_CALL;
  logic           i_RET;
  logic [AW-1:0]  o_PC;
  logic [SPW-1:0] o_SP;
  logic           o_STK_EMPTY;
  logic           o_STK_FULL;
  logic           o_ERR;

  modport master (
    output i_EN, i_SEL_JMP, i_JMP_ADDR, i_SEL_BR, i_BR_OFF, i_CALL, i_RET,
    input  o_PC, o_SP, o_STK_EMPTY, o_STK_FULL, o_ERR
  );

  modport slave (
    input  i_EN, i_SEL_JMP, i_JMP_ADDR, i_SEL_BR, i_BR_OFF, i_CALL, i_RET,
    output o_PC, o_SP, o_STK_EMPTY, o_STK_FULL, o_ERR
  );
endinterface

// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with a hardware return-address stack.
// Priority when enabled: RET, CALL, absolute jump, relative branch, increment.
// Stack misuse (pop when empty, push when full) falls through to an
// increment and raises a sticky error instead of stalling the core.
module pc_stack_seq #(
  parameter int          AW       = 8,
  parameter int          DEPTH    = 4,
  parameter int          OW       = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b1}}
) (
  input logic         i_CLK,
  input logic         i_RST,
  pc_stack_seq_if.slave bus
);
  localparam int SPW = $clog2(DEPTH) + 1;
  localparam int IW  = $clog2(DEPTH);

  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic           push_we;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  br_ext;
  logic [SPW-1:0] sp_top;
  logic           stk_empty;
  logic           stk_full;

  assign pc_inc    = pc_q + AW'(1);
  assign br_ext    = AW'($signed(bus.i_BR_OFF));
  assign sp_top    = sp_q - SPW'(1);
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SPW'(DEPTH));

  // Next-state selection: hold everything on stall, otherwise apply the
  // highest-priority request.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_we = 1'b0;
    if (bus.i_EN) begin
      if (bus.i_RET) begin
        if (!stk_empty) begin
          pc_d = stack_q[sp_top[IW-1:0]];
          sp_d = sp_top;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (bus.i_CALL) begin
        if (!stk_full) begin
          push_we = 1'b1;
          sp_d    = sp_q + SPW'(1);
          pc_d    = bus.i_JMP_ADDR;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (bus.i_SEL_JMP) begin
        pc_d = bus.i_JMP_ADDR;
      end else if (bus.i_SEL_BR) begin
        pc_d = pc_q + br_ext;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge i_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_RST) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Return-address storage, written on push only.
  always_ff @(posedge i_CLK) begin
    // NOTE: the stack array is deliberately not reset; o_SP=0 makes stale
    // entries unreachable, and leaving it unreset lets it map to plain RAM.
    if (i_RST && push_we) begin
      stack_q[sp_q[IW-1:0]] <= pc_inc;
    end
  end

  assign bus.o_PC        = pc_q;
  assign bus.o_SP        = sp_q;
  assign bus.o_STK_EMPTY = stk_empty;
  assign bus.o_STK_FULL  = stk_full;
  assign bus.o_ERR       = err_q;
endmodule

// File: tb/tb_pc_stack_seq.sv
// Directed bench for pc_stack_seq (AW=8, DEPTH=4, OW=4).
module tb_pc_stack_seq;
  typedef struct {
    logic       rst_n;
    logic       en;
    logic       jmp;
    logic [7:0] addr;
    logic       br;
    logic [3:0] off;
    logic       call;
    logic       ret;
    logic [7:0] e_pc;
    logic [2:0] e_sp;
    logic       e_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t tbl[$];

  pc_stack_seq_if #(.AW(8), .DEPTH(4), .OW(4)) bus ();

  pc_stack_seq #(.AW(8), .DEPTH(4), .OW(4), .RESET_PC(8'hFF)) dut (
    .i_CLK (clk),
    .i_RST (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic r, input logic en, input logic jmp,
                               input logic [7:0] addr, input logic br,
                               input logic [3:0] off, input logic call,
                               input logic ret, input logic [7:0] e_pc,
                               input logic [2:0] e_sp, input logic e_err);
    vec_t v;
    v.rst_n = r;    v.en = en;     v.jmp = jmp;   v.addr = addr;
    v.br    = br;   v.off = off;   v.call = call; v.ret = ret;
    v.e_pc  = e_pc; v.e_sp = e_sp; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one vector, clock it, then compare all outputs 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    rst_n          = v.rst_n;
    bus.i_EN       = v.en;
    bus.i_SEL_JMP  = v.jmp;
    bus.i_JMP_ADDR = v.addr;
    bus.i_SEL_BR   = v.br;
    bus.i_BR_OFF   = v.off;
    bus.i_CALL     = v.call;
    bus.i_RET      = v.ret;
    @(posedge clk);
    #1;
    check({tag, "_pc"},    32'(bus.o_PC),        32'(v.e_pc));
    check({tag, "_sp"},    32'(bus.o_SP),        32'(v.e_sp));
    check({tag, "_err"},   32'(bus.o_ERR),       32'(v.e_err));
    check({tag, "_empty"}, 32'(bus.o_STK_EMPTY), 32'(v.e_sp == 3'd0));
    check({tag, "_full"},  32'(bus.o_STK_FULL),  32'(v.e_sp == 3'd4));
  endtask

  // Shorthands: plain step, reset, jump, call, ret.
  function automatic vec_t inc(input logic [7:0] p, input logic [2:0] s,
                               input logic e);
    return mkv(1, 1, 0, 8'h00, 0, 4'h0, 0, 0, p, s, e);
  endfunction
  function automatic vec_t rst_v();
    return mkv(0, 1, 0, 8'h00, 0, 4'h0, 0, 0, 8'hFF, 3'd0, 0);
  endfunction
  function automatic vec_t jmp_v(input logic [7:0] a, input logic [2:0] s,
                                 input logic e);
    return mkv(1, 1, 1, a, 0, 4'h0, 0, 0, a, s, e);
  endfunction
  function automatic vec_t call_v(input logic [7:0] a, input logic [7:0] p,
                                  input logic [2:0] s, input logic e);
    return mkv(1, 1, 0, a, 0, 4'h0, 1, 0, p, s, e);
  endfunction
  function automatic vec_t ret_v(input logic [7:0] p, input logic [2:0] s,
                                 input logic e);
    return mkv(1, 1, 0, 8'h00, 0, 4'h0, 0, 1, p, s, e);
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_EN = 1'b0; bus.i_SEL_JMP = 1'b0; bus.i_JMP_ADDR = '0;
    bus.i_SEL_BR = 1'b0; bus.i_BR_OFF = '0; bus.i_CALL = 1'b0; bus.i_RET = 1'b0;

    // Reset, increment, stall, jump, branch, nested call/return.
    tbl.push_back(rst_v());
    tbl.push_back(rst_v());
    for (int k = 0; k <= 5; k++) tbl.push_back(inc(8'(k), 3'd0, 0));
    tbl.push_back(mkv(1, 0, 0, 8'h00, 0, 4'h0, 0, 0, 8'h05, 3'd0, 0));
    tbl.push_back(mkv(1, 0, 1, 8'hAA, 0, 4'h0, 0, 0, 8'h05, 3'd0, 0));
    tbl.push_back(mkv(1, 0, 0, 8'h77, 0, 4'h0, 1, 1, 8'h05, 3'd0, 0));
    tbl.push_back(jmp_v(8'h40, 3'd0, 0));
    tbl.push_back(mkv(1, 1, 0, 8'h00, 1, 4'hE, 0, 0, 8'h3E, 3'd0, 0));
    tbl.push_back(jmp_v(8'hFE, 3'd0, 0));
    tbl.push_back(mkv(1, 1, 0, 8'h00, 1, 4'h7, 0, 0, 8'h05, 3'd0, 0));
    tbl.push_back(jmp_v(8'h10, 3'd0, 0));
    tbl.push_back(call_v(8'h80, 8'h80, 3'd1, 0));
    tbl.push_back(inc(8'h81, 3'd1, 0));
    tbl.push_back(call_v(8'hC0, 8'hC0, 3'd2, 0));
    tbl.push_back(ret_v(8'h82, 3'd1, 0));
    tbl.push_back(ret_v(8'h11, 3'd0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Free-run from 0x11 through 0xFF and wrap to 0x00.
    for (int k = 'h12; k <= 'h100; k++) apply(inc(8'(k), 3'd0, 0), "wrap");

    // Overflow: fill the stack, fifth call errors, unwind LIFO.
    apply(rst_v(), "ov_rst");
    apply(jmp_v(8'h10, 3'd0, 0), "ov_j");
    apply(call_v(8'h20, 8'h20, 3'd1, 0), "ov_c1");
    apply(call_v(8'h30, 8'h30, 3'd2, 0), "ov_c2");
    apply(call_v(8'h40, 8'h40, 3'd3, 0), "ov_c3");
    apply(call_v(8'h50, 8'h50, 3'd4, 0), "ov_c4");
    apply(jmp_v(8'hA0, 3'd4, 0), "ov_ja0");
    apply(call_v(8'h60, 8'hA1, 3'd4, 1), "ov_c5");
    apply(ret_v(8'h41, 3'd3, 1), "ov_r1");
    apply(ret_v(8'h31, 3'd2, 1), "ov_r2");
    apply(ret_v(8'h21, 3'd1, 1), "ov_r3");
    apply(ret_v(8'h11, 3'd0, 1), "ov_r4");

    // Underflow: pop on empty stack increments and flags.
    apply(rst_v(), "un_rst");
    apply(jmp_v(8'h20, 3'd0, 0), "un_j");
    apply(ret_v(8'h21, 3'd0, 1), "un_r");

    // Priority: CALL+RET+SEL_JMP together performs only the RET.
    apply(rst_v(), "pr_rst");
    apply(jmp_v(8'h32, 3'd0, 0), "pr_j");
    apply(call_v(8'h70, 8'h70, 3'd1, 0), "pr_c");
    apply(mkv(1, 1, 1, 8'h99, 0, 4'h0, 1, 1, 8'h33, 3'd0, 0), "pr_all");

    // Return address wraps: call from 0xFF pushes 0x00.
    apply(jmp_v(8'hFF, 3'd0, 0), "rw_j");
    apply(call_v(8'h44, 8'h44, 3'd1, 0), "rw_c");
    apply(ret_v(8'h00, 3'd0, 0), "rw_r");

    // Back-to-back call/return, then reset while stalled with SP=3.
    apply(jmp_v(8'h10, 3'd0, 0), "mr_j");
    apply(call_v(8'h20, 8'h20, 3'd1, 0), "mr_c1");
    apply(call_v(8'h30, 8'h30, 3'd2, 0), "mr_c2");
    apply(call_v(8'h40, 8'h40, 3'd3, 0), "mr_c3");
    apply(ret_v(8'h31, 3'd2, 0), "mr_r");
    apply(call_v(8'h40, 8'h40, 3'd3, 0), "mr_c4");
    apply(mkv(0, 0, 0, 8'h00, 0, 4'h0, 0, 0, 8'hFF, 3'd0, 0), "mr_rst");
    apply(ret_v(8'h00, 3'd0, 1), "mr_under");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
